ddr_wr_fifo: RTL
================

# ddr_wr_fifo

Write-side request buffer between the traffic generator and the DDR `fifo_to_app` dispatcher. It accepts write requests carrying a 27-bit address and 128-bit data, and queues each address for `fifo_to_app` to issue as a write command. It streams each data word to the memory controller's write-data interface as two 64-bit beats, low half first. It is the transmit counterpart of `ddr_rd_fifo`: that block reassembles two 64-bit read beats into one word, and this block splits one word into two write beats.

## Interface
Parameters:
- `DEPTH`, 64, entries in each internal FIFO; power of two.
- `ADX_W`, 27, address width.
- `DATA_W`, 128, request data width; beat width is `DATA_W/2`.

Ports:
- `clk`, in, 1: single clock.
- `resetn`, in, 1: reset, **synchronous, active-low**.
- `write_address`, in, `ADX_W`: request address.
- `write_data`, in, `DATA_W`: request data.
- `write_req`, in, 1: request strobe; ignored unless `write_allowed`.
- `write_allowed`, out, 1: at least one free entry exists in both FIFOs.
- `writes_pending`, out, 1: any address or data is still held, or a burst is in progress.
- `f2a_wr_adx`, out, `ADX_W`: head of the address FIFO (first-word-fall-through).
- `f2a_has_wr_req`, out, 1: address FIFO is not empty.
- `f2a_get_wr_adr`, in, 1: pops the address FIFO; ignored when it is empty.
- `app_wdf_data`, out, `DATA_W/2`: write beat.
- `app_wdf_wren`, out, 1: beat valid.
- `app_wdf_end`, out, 1: marks the second (last) beat.
- `app_wdf_mask`, out, `DATA_W/16`: tied to 0.
- `app_wdf_rdy`, in, 1: controller accepts the beat this cycle.

## Operation
- Legal push: `write_req & write_allowed`. A legal push writes `write_address` into the address FIFO and `write_data` into the data FIFO in the same cycle.
- `write_allowed` = address count < `DEPTH` && data count < `DEPTH`. It is combinational from the registered counts.
- Occupancy counts are `$clog2(DEPTH)+1` bits wide, so that a count equal to `DEPTH` can be represented.
- `writes_pending` = address FIFO not empty || data FIFO not empty || `state != IDLE`.
- The address path and the data path drain independently. The controller tolerates write data arriving ahead of its command. Ordering between addresses and data words is preserved because both FIFOs are strict FIFOs filled together.

Beat FSM states:
- **IDLE**:
  - Outputs: `wren=0`, `end=0`.
  - If the data FIFO is not empty: load its head into the 128-bit `hold` register, pop it, and go to `LO`.
- **LO**:
  - Outputs: `app_wdf_data=hold[63:0]`, `wren=1`, `end=0`.
  - If `app_wdf_rdy`, go to `HI`; otherwise stay in `LO` with all outputs held.
- **HI**:
  - Outputs: `app_wdf_data=hold[127:64]`, `wren=1`, `end=1`.
  - If `app_wdf_rdy` and the data FIFO is not empty: load and pop the next word, and go to `LO` (back-to-back, no bubble).
  - If `app_wdf_rdy` and the data FIFO is empty: go to `IDLE`.
  - If not `app_wdf_rdy`: hold.

Boundary conditions:
- Push and pop in the same cycle on either FIFO: the count is unchanged, and the data stays correct at `DEPTH-1` and at 1.
- Push into an empty FIFO while a pop is requested: the pop is ignored, the push succeeds, and the count becomes 1.
- A full FIFO deasserts `write_allowed`. A `write_req` while not allowed changes nothing.
- FIFO pointers wrap modulo `DEPTH` with no loss.
- Reset mid-burst: on the next edge the state is `IDLE`, both FIFOs are empty, and the partial burst is dropped.

## Timing
- Reset values:
  - `write_allowed=1`, `writes_pending=0`, `f2a_has_wr_req=0`.
  - `app_wdf_wren=0`, `app_wdf_end=0`.
  - `app_wdf_data=0` (`hold` cleared), `f2a_wr_adx` don't-care (X is allowed).
- Push at edge N:
  - `f2a_has_wr_req=1` in cycle N+1.
  - The data FIFO is not empty in N+1, so the FSM loads `hold` at edge N+1 and the LO beat appears in cycle N+2.
  - With `app_wdf_rdy` held high, the HI beat appears in N+3.
- With `rdy` held high, sustained throughput is one 128-bit word per two cycles.
- An address pop at edge N presents the next head on `f2a_wr_adx` in N+1.

## Structure
- A shared package `ddr_pkg` holds `ADX_W`, `DATA_W`, `DEPTH`, and the FSM state encoding (`IDLE`, `LO`, `HI`).
- Sub-module `ddr_sync_fifo`:
  - Parameterized width and depth, first-word-fall-through, synchronous active-low reset.
  - Ports: `count`, `empty`, `full`.
  - Instantiated twice: once for addresses (`ADX_W`) and once for data (`DATA_W`).
- The beat FSM and `hold` register live in the top module.

## Test plan
- After reset: `write_allowed=1`, `writes_pending=0`, `wren=0`. Push address 0x0000010 with data 0x1111…_2222… while `rdy=1` → LO beat 0x2222… at N+2 and HI beat 0x1111… with `end=1` at N+3. `f2a_wr_adx=0x10`.
- Backpressure: hold `rdy=0` for 5 cycles during LO → LO data is stable and `wren=1` for all 5 cycles. Release → HI beat follows.
- Fill: push 64 requests with no address pops and `rdy=0` → `write_allowed=0` after the 64th push (the data FIFO holds 63, plus 1 in `hold`, so the address FIFO is the limiter). A 65th `write_req` is ignored.
- Wrap: push and pop 200 sequential addresses and data words → all beats and addresses come out in order with no gaps; back-to-back `LO`/`HI` streaming has no idle cycle.
- Simultaneous push and `f2a_get_wr_adr` with the address FIFO empty → the pop is ignored and the count becomes 1.
- Reset asserted in `HI` with 3 words queued → next cycle `wren=0`, `writes_pending=0`, `f2a_has_wr_req=0`.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared constants and beat-FSM encoding for the DDR request buffers.
package ddr_pkg;

  localparam int ADX_W  = 27;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } beat_state_e;

endpackage

// File: rtl/ddr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// The head entry is always visible on o_rdata while the FIFO is not empty.
module ddr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Requests against a full/empty FIFO are dropped here, so callers may be loose.
  assign w_push = i_push & ~full;
  assign w_pop  = i_pop & ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_COUNT);

endmodule

// File: rtl/ddr_wr_fifo.sv
// Write-side request buffer: queues addresses for fifo_to_app and streams
// each 128-bit data word to the controller as two beats, low half first.
module ddr_wr_fifo #(
  parameter int DEPTH  = ddr_pkg::DEPTH,
  parameter int ADX_W  = ddr_pkg::ADX_W,
  parameter int DATA_W = ddr_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADX_W-1:0]      write_address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  write_req,
  output logic                  write_allowed,
  output logic                  writes_pending,
  output logic [ADX_W-1:0]      f2a_wr_adx,
  output logic                  f2a_has_wr_req,
  input  logic                  f2a_get_wr_adr,
  output logic [DATA_W/2-1:0]   app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W/16-1:0]  app_wdf_mask,
  input  logic                  app_wdf_rdy
);

  import ddr_pkg::*;

  localparam int BEAT_W = DATA_W / 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]     w_adx_count;
  logic [CW-1:0]     w_data_count;
  logic              w_adx_empty;
  logic              w_data_empty;
  logic              w_adx_full;
  logic              w_data_full;
  logic [DATA_W-1:0] w_data_head;
  logic              w_push;
  logic              w_data_pop;

  beat_state_e       r_state;
  logic [DATA_W-1:0] r_hold;
  logic [BEAT_W-1:0] r_beat;
  logic              r_wren;
  logic              r_end;

  assign write_allowed = (w_adx_count < DEPTH_C) && (w_data_count < DEPTH_C)
                         && !w_adx_full && !w_data_full;
  assign w_push        = write_req & write_allowed;

  ddr_sync_fifo #(.WIDTH(ADX_W), .DEPTH(DEPTH)) u_adx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (write_address),
    .i_pop   (f2a_get_wr_adr),
    .o_rdata (f2a_wr_adx),
    .count   (w_adx_count),
    .empty   (w_adx_empty),
    .full    (w_adx_full)
  );

  ddr_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (write_data),
    .i_pop   (w_data_pop),
    .o_rdata (w_data_head),
    .count   (w_data_count),
    .empty   (w_data_empty),
    .full    (w_data_full)
  );

  // A word leaves the data FIFO whenever the FSM is about to start a new LO beat.
  assign w_data_pop = !w_data_empty &&
                      ((r_state == IDLE) || ((r_state == HI) && app_wdf_rdy));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_beat  <= '0;
      r_wren  <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_data_empty) begin
            r_hold  <= w_data_head;
            r_beat  <= w_data_head[BEAT_W-1:0];
            r_wren  <= 1'b1;
            r_end   <= 1'b0;
            r_state <= LO;
          end
        end
        LO: begin
          if (app_wdf_rdy) begin
            r_beat  <= r_hold[DATA_W-1:BEAT_W];
            r_end   <= 1'b1;
            r_state <= HI;
          end
        end
        HI: begin
          if (app_wdf_rdy) begin
            if (!w_data_empty) begin
              r_hold  <= w_data_head;
              r_beat  <= w_data_head[BEAT_W-1:0];
              r_wren  <= 1'b1;
              r_end   <= 1'b0;
              r_state <= LO;
            end else begin
              r_wren  <= 1'b0;
              r_end   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_wren  <= 1'b0;
          r_end   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign writes_pending = !w_adx_empty || !w_data_empty || (r_state != IDLE);
  assign f2a_has_wr_req = !w_adx_empty;
  assign app_wdf_data   = r_beat;
  assign app_wdf_wren   = r_wren;
  assign app_wdf_end    = r_end;
  assign app_wdf_mask   = '0;

endmodule
